// File: rtl/pkt_prio_sort_queue.sv
// ---------------------------------------------------------------------------
// pkt_prio_sort_queue
//
// A stable, sorted buffer that sits after the packet priority stage. Every
// upstream word is taken on the cycle it arrives (there is no input ready).
// The word with the lowest priority value is always presented at the head.
// Words with equal priority leave in arrival order.
//
// When the buffer is full and a word arrives with no pop in the same cycle,
// exactly one word is dropped:
//   - If the new word beats the tail, the tail (the worst and youngest entry)
//     is evicted and the new word is inserted.
//   - Otherwise the new word itself is discarded.
//
// Ports
//   clk        : clock
//   rst        : asynchronous, active-high reset
//   in_valid   : upstream word present (always accepted)
//   in_data    : upstream payload
//   in_prior   : upstream priority (unsigned, smaller = served first)
//   out_valid  : head slot occupied
//   out_ready  : consumer accepts head this cycle
//   out_data   : head payload (0 when empty)
//   out_prior  : head priority (0 when empty)
//   count      : number of occupied slots
//   full       : count == DEPTH
//   drop_pulse : registered, a drop happened on the previous edge
//   drop_cnt   : saturating total of drops
//
// Handshake: a head word transfers on a rising clk edge where
// out_valid && out_ready. out_valid never depends on out_ready. The head may
// be replaced by a better arrival while it waits, so the consumer must only
// sample out_data/out_prior on the transfer edge.
// ---------------------------------------------------------------------------
module pkt_prio_sort_queue #(
    parameter int DWIDTH      = 32,
    parameter int PRIOR_WIDTH = 6,
    parameter int DEPTH       = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DWIDTH-1:0]            in_data,
    input  logic [PRIOR_WIDTH-1:0]       in_prior,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DWIDTH-1:0]            out_data,
    output logic [PRIOR_WIDTH-1:0]       out_prior,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         drop_pulse,
    output logic [CNT_WIDTH-1:0]         drop_cnt
);

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    // Slot storage. Occupied slots are always 0..count_q-1, sorted ascending
    // by priority, oldest first within a priority.
    logic [DWIDTH-1:0]      data_q  [DEPTH];
    logic [PRIOR_WIDTH-1:0] prior_q [DEPTH];
    logic [CW-1:0]          count_q;
    logic                   drop_q;
    logic [CNT_WIDTH-1:0]   drop_cnt_q;

    // Stage "s": contents after the pop has been applied.
    logic [DWIDTH-1:0]      s_data  [DEPTH];
    logic [PRIOR_WIDTH-1:0] s_prior [DEPTH];
    logic [CW-1:0]          s_cnt;

    // Stage "u": stage s shifted up by one slot, used behind the insert point.
    logic [DWIDTH-1:0]      u_data  [DEPTH];
    logic [PRIOR_WIDTH-1:0] u_prior [DEPTH];

    // Next-state contents.
    logic [DWIDTH-1:0]      n_data  [DEPTH];
    logic [PRIOR_WIDTH-1:0] n_prior [DEPTH];
    logic [CW-1:0]          n_cnt;

    logic                   pop;
    logic                   ins;
    logic                   drop;
    logic [CW-1:0]          pos;

    always_comb begin
        pop   = (count_q != '0) && out_ready;
        ins   = 1'b0;
        drop  = 1'b0;
        pos   = '0;
        n_cnt = count_q;

        // Pop first: everything moves down one slot.
        for (int i = 0; i < DEPTH - 1; i++) begin
            s_data[i]  = pop ? data_q[i+1]  : data_q[i];
            s_prior[i] = pop ? prior_q[i+1] : prior_q[i];
        end
        s_data[DEPTH-1]  = pop ? '0 : data_q[DEPTH-1];
        s_prior[DEPTH-1] = pop ? '0 : prior_q[DEPTH-1];
        s_cnt            = pop ? count_q - 1'b1 : count_q;

        // Insert point: just after the last occupied slot with prior <= new.
        // The list is sorted, so the last match wins.
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < s_cnt) && (s_prior[i] <= in_prior)) begin
                pos = CW'(i + 1);
            end
        end

        u_data[0]  = s_data[0];
        u_prior[0] = s_prior[0];
        for (int i = 1; i < DEPTH; i++) begin
            u_data[i]  = s_data[i-1];
            u_prior[i] = s_prior[i-1];
        end

        // After a pop there is always room, so a drop can only happen when
        // the buffer is full and there is no pop. In that case the new word
        // is inserted only if it beats the tail; the shift-up then pushes the
        // tail out of the last slot.
        if (in_valid) begin
            if (s_cnt != DEPTH_C) begin
                ins = 1'b1;
            end else begin
                drop = 1'b1;
                ins  = (in_prior < s_prior[DEPTH-1]);
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (!ins || (CW'(i) < pos)) begin
                n_data[i]  = s_data[i];
                n_prior[i] = s_prior[i];
            end else if (CW'(i) == pos) begin
                n_data[i]  = in_data;
                n_prior[i] = in_prior;
            end else begin
                n_data[i]  = u_data[i];
                n_prior[i] = u_prior[i];
            end
        end

        if (ins && !drop) begin
            n_cnt = s_cnt + 1'b1;
        end else begin
            n_cnt = s_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                prior_q[i] <= '0;
            end
            count_q    <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= n_data[i];
                prior_q[i] <= n_prior[i];
            end
            count_q <= n_cnt;
            drop_q  <= drop;
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    // Stale words may remain in slots that are no longer occupied, so the
    // head outputs are forced to zero when the buffer is empty.
    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? data_q[0]  : '0;
    assign out_prior  = out_valid ? prior_q[0] : '0;
    assign count      = count_q;
    assign full       = (count_q == DEPTH_C);
    assign drop_pulse = drop_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
